// File: rtl/tw_rom_seq_ctrl_pkg.sv
// Shared types and codes for the twiddle-ROM sequencer: FSM states, ROM
// write strobes, phase codes and the load-buffer depth.
package tw_rom_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH_HI = 3'd1,
    S_FLUSH_LO = 3'd2,
    S_RUN      = 3'd3,
    S_GAP      = 3'd4,
    S_FIN      = 3'd5
  } fsm_e;

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_HI   = 2'd1;
  localparam logic [1:0] W_LO   = 2'd2;

  localparam logic [3:0] PH_IDLE   = 4'd0;
  localparam logic [3:0] PH_FIRST  = 4'd4;
  localparam logic [3:0] PH_SECOND = 4'd6;

  localparam int LOAD_BEATS = 8;
  localparam int HALF_BEATS = LOAD_BEATS / 2;

endpackage

// File: rtl/tw_rom_seq_ctrl_if.sv
// Host load-beat channel into the twiddle-ROM sequencer.
interface tw_rom_seq_ctrl_if #(
  parameter int HDW = 64
) ();
  // A beat transfers on a rising CLK edge where ld_valid && ld_ready. The
  // master holds ld_valid/ld_data stable until that edge; ld_ready never
  // depends combinationally on ld_valid.
  logic           ld_valid;
  logic [HDW-1:0] ld_data;
  logic           ld_ready;

  modport master (output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/tw_rom_seq_ctrl_load_buf.sv
// Eight-beat staging buffer: beats 0..3 are high halves, 4..7 low halves of
// ROM words 0..3. Tracks fill count and whether the content is unflushed.
module tw_load_buf
  import tw_rom_ctrl_pkg::*;
#(
  parameter int HDW = 64
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           ld_valid,
  input  logic [HDW-1:0] ld_data,
  output logic           ld_ready,
  input  logic           idle_next,
  input  logic           flush_done,
  input  logic           rd_lo,
  input  logic [1:0]     rd_idx,
  output logic [HDW-1:0] rd_data,
  output logic [3:0]     beat_cnt,
  output logic           dirty
);

  localparam logic [3:0] FULL = 4'(LOAD_BEATS);

  logic [HDW-1:0] mem [LOAD_BEATS];
  logic [3:0]     cnt_d;
  logic           dirty_d;
  logic           accept;

  assign accept  = ld_valid && ld_ready;
  assign rd_data = mem[{rd_lo, rd_idx}];

  always_comb begin
    cnt_d   = beat_cnt;
    dirty_d = dirty;
    if (flush_done) begin
      cnt_d   = 4'd0;
      dirty_d = 1'b0;
    end else if (accept) begin
      cnt_d = beat_cnt + 4'd1;
      if (beat_cnt == FULL - 4'd1) dirty_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      beat_cnt <= 4'd0;
      dirty    <= 1'b0;
      ld_ready <= 1'b1;
    end else begin
      beat_cnt <= cnt_d;
      dirty    <= dirty_d;
      ld_ready <= idle_next && (cnt_d < FULL);
    end
  end

  // Payload storage carries no reset; a partially filled buffer is never read.
  always_ff @(posedge CLK) begin
    if (accept) mem[beat_cnt[2:0]] <= ld_data;
  end

endmodule

// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle-ROM sequencer: flushes the host load buffer into stage-0, then walks
// every NTT stage with CEN/phase/stage_counter. Optional TW_ROM_CTRL_PERF_EN.
module tw_rom_seq_ctrl
  import tw_rom_ctrl_pkg::*;
#(
  parameter int SC_WIDTH   = 3,
  parameter int S_WIDTH    = 4,
  parameter int HDW        = 64,
  parameter int NUM_STAGES = 3,
  parameter int STAGE_LEN  = 1024,
  parameter int LEN_W      = 11,
  parameter int GAP_CYC    = 1
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  tw_rom_seq_ctrl_if.slave    ld,
  output logic                busy,
  output logic                done,
  output logic                stage_done,
  output logic [SC_WIDTH-1:0] stage_counter,
  output logic                CEN,
  output logic [S_WIDTH-1:0]  state,
  output logic [HDW-1:0]      horizontal_data_out,
  output logic [1:0]          ROM7_w,
  output fsm_e                fsm_dbg
`ifdef TW_ROM_CTRL_PERF_EN
  ,
  input  logic                perf_clr,
  output logic [31:0]         perf_cnt
`endif
);

  localparam int G_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [SC_WIDTH-1:0] SC_OFF  = SC_WIDTH'(NUM_STAGES);
  localparam logic [SC_WIDTH-1:0] SC_LAST = SC_WIDTH'(NUM_STAGES - 1);
  localparam logic [LEN_W-1:0]    C_LAST  = LEN_W'(STAGE_LEN - 1);
  localparam logic [LEN_W-1:0]    C_HALF  = LEN_W'(STAGE_LEN / 2);
  localparam logic [G_W-1:0]      G_LAST  = G_W'(GAP_CYC - 1);
  localparam logic [1:0]          I_LAST  = 2'(HALF_BEATS - 1);
  localparam logic [3:0]          FULL    = 4'(LOAD_BEATS);

  fsm_e                state_q, state_d;
  logic [SC_WIDTH-1:0] s_q, s_d;
  logic [LEN_W-1:0]    c_q, c_d;
  logic [1:0]          fi_q, fi_d;
  logic [G_W-1:0]      g_q, g_d;

  logic [3:0]     beat_cnt;
  logic           dirty;
  logic           idle_next;
  logic           flush_done;
  logic           rd_lo;
  logic [HDW-1:0] rd_data;

  logic                busy_d, done_d, sdone_d, cen_d;
  logic [SC_WIDTH-1:0] sc_d;
  logic [S_WIDTH-1:0]  ph_d;
  logic [HDW-1:0]      hdo_d;
  logic [1:0]          w_d;

  assign fsm_dbg    = state_q;
  assign idle_next  = (state_d == S_IDLE);
  assign rd_lo      = (state_d == S_FLUSH_LO);
  assign flush_done = (state_q == S_FLUSH_LO) && (fi_q == I_LAST) && !abort;

  tw_load_buf #(.HDW(HDW)) u_load_buf (
    .CLK        (CLK),
    .rst        (rst),
    .ld_valid   (ld.ld_valid),
    .ld_data    (ld.ld_data),
    .ld_ready   (ld.ld_ready),
    .idle_next  (idle_next),
    .flush_done (flush_done),
    .rd_lo      (rd_lo),
    .rd_idx     (fi_d),
    .rd_data    (rd_data),
    .beat_cnt   (beat_cnt),
    .dirty      (dirty)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      c_q     <= '0;
      fi_q    <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      fi_q    <= fi_d;
      g_q     <= g_d;
    end
  end

  // abort overrides every transition, including a start in the same cycle.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    fi_d    = fi_q;
    g_d     = g_q;
    if (abort) begin
      state_d = S_IDLE;
      s_d     = '0;
      c_d     = '0;
      fi_d    = '0;
      g_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (beat_cnt == FULL && dirty) begin
              state_d = S_FLUSH_HI;
              fi_d    = '0;
            end else if (beat_cnt == 4'd0 || beat_cnt == FULL) begin
              state_d = S_RUN;
              s_d     = '0;
              c_d     = '0;
            end
          end
        end
        S_FLUSH_HI: begin
          fi_d = fi_q + 2'd1;
          if (fi_q == I_LAST) state_d = S_FLUSH_LO;
        end
        S_FLUSH_LO: begin
          fi_d = fi_q + 2'd1;
          if (fi_q == I_LAST) begin
            state_d = S_RUN;
            s_d     = '0;
            c_d     = '0;
          end
        end
        S_RUN: begin
          if (c_q == C_LAST) begin
            c_d     = '0;
            g_d     = '0;
            state_d = (s_q == SC_LAST) ? S_FIN : S_GAP;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
        S_GAP: begin
          if (g_q == G_LAST) begin
            state_d = S_RUN;
            s_d     = s_q + 1'b1;
            c_d     = '0;
          end else begin
            g_d = g_q + 1'b1;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          s_d     = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copy lines up
  // with the cycle that state is actually occupied.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    cen_d   = (state_d != S_RUN);
    sdone_d = (state_d == S_RUN) && (c_d == C_LAST);
    sc_d    = SC_OFF;
    ph_d    = S_WIDTH'(PH_IDLE);
    w_d     = W_NONE;
    hdo_d   = '0;
    case (state_d)
      S_RUN: begin
        sc_d = s_d;
        ph_d = (c_d < C_HALF) ? S_WIDTH'(PH_FIRST) : S_WIDTH'(PH_SECOND);
      end
      S_GAP: sc_d = s_d;
      S_FLUSH_HI: begin
        w_d   = W_HI;
        hdo_d = rd_data;
      end
      S_FLUSH_LO: begin
        w_d   = W_LO;
        hdo_d = rd_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      busy                <= 1'b0;
      done                <= 1'b0;
      stage_done          <= 1'b0;
      stage_counter       <= SC_OFF;
      CEN                 <= 1'b1;
      state               <= S_WIDTH'(PH_IDLE);
      horizontal_data_out <= '0;
      ROM7_w              <= W_NONE;
    end else begin
      busy                <= busy_d;
      done                <= done_d;
      stage_done          <= sdone_d;
      stage_counter       <= sc_d;
      CEN                 <= cen_d;
      state               <= ph_d;
      horizontal_data_out <= hdo_d;
      ROM7_w              <= w_d;
    end
  end

`ifdef TW_ROM_CTRL_PERF_EN
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
    end else if (perf_clr) begin
      perf_cnt <= '0;
    end else if (!CEN && perf_cnt != 32'hFFFF_FFFF) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule
